// File: rtl/bram_pkg.sv
// Shared types and helpers for the byte-enable block RAM (bram_be).
package bram_pkg;

  // Widest word merge_be can handle; callers cast to and from their own width.
  localparam int unsigned MERGE_MAX_W  = 1024;
  localparam int unsigned MERGE_MAX_BE = MERGE_MAX_W / 8;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

  // Byte-merge: take bytes of new_w where be is set, keep old_w elsewhere.
  function automatic logic [MERGE_MAX_W-1:0] merge_be(
    input logic [MERGE_MAX_W-1:0]  old_w,
    input logic [MERGE_MAX_W-1:0]  new_w,
    input logic [MERGE_MAX_BE-1:0] be
  );
    logic [MERGE_MAX_W-1:0] r;
    r = old_w;
    for (int i = 0; i < int'(MERGE_MAX_BE); i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_clear_fsm.sv
// Clear engine for bram_be: walks every address once, writing zero, while busy is high.
module bram_clear_fsm
  import bram_pkg::*;
#(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter bit          AUTO_CLR   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam clr_state_t            RST_STATE = AUTO_CLR ? CLR_RUN : CLR_IDLE;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  clr_state_t            r_state;
  clr_state_t            w_state_nx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nx;
  logic                  r_busy;

  // State, address counter and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_STATE;
      r_addr  <= '0;
      r_busy  <= AUTO_CLR;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_busy  <= (w_state_nx == CLR_RUN);
    end
  end

  // Next state; clr is ignored while a clear is already running.
  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    case (r_state)
      CLR_IDLE: begin
        if (clr) begin
          w_state_nx = CLR_RUN;
          w_addr_nx  = '0;
        end
      end
      CLR_RUN: begin
        w_addr_nx = r_addr + ADDR_WIDTH'(1);
        if (r_addr == LAST_ADDR) begin
          w_state_nx = CLR_IDLE;
          w_addr_nx  = '0;
        end
      end
      default: begin
        w_state_nx = CLR_IDLE;
        w_addr_nx  = '0;
      end
    endcase
  end

  assign busy     = r_busy;
  assign clr_we   = (r_state == CLR_RUN);
  assign clr_addr = r_addr;

endmodule

// File: rtl/bram_be.sv
// Simple-dual-port RAM with byte enables, write-first forwarding and a clear engine.
// Define BRAM_BE_OUTREG_EN to add an output register stage (read latency 2).
module bram_be
  import bram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter string       MEM_FILE   = "",
  parameter bit          INIT_CLEAR = 1'b1,
  localparam int unsigned ADDR_WIDTH = (DEPTH <= 1) ? 1 : $clog2(DEPTH),
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  rden,
  input  logic [ADDR_WIDTH-1:0] rdaddr,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  rvalid,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] wraddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BE_WIDTH-1:0]   wbe
);

  localparam bit HAS_FILE = (MEM_FILE != "");
  localparam bit AUTO_CLR = INIT_CLEAR && !HAS_FILE;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_busy;
  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;

  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic                  w_user_we;
  logic                  w_rd_ok;
  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_rd_word;

  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [BE_WIDTH-1:0]   w_wbe;

  logic [DATA_WIDTH-1:0] r_q;
  logic                  r_rvalid;

  bram_clear_fsm #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .AUTO_CLR   (AUTO_CLR)
  ) u_clear (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  // Compare in 32 bits so a power-of-two DEPTH does not wrap to zero.
  assign w_wr_in_range = (32'(wraddr) < DEPTH);
  assign w_rd_in_range = (32'(rdaddr) < DEPTH);
  assign w_user_we     = wren && !w_busy && w_wr_in_range;
  assign w_rd_ok       = rden && !w_busy;
  assign w_collide     = w_user_we && (wraddr == rdaddr);

  // Clear engine owns the write port while running.
  assign w_we    = w_clr_we || w_user_we;
  assign w_waddr = w_clr_we ? w_clr_addr : wraddr;
  assign w_wdata = w_clr_we ? '0 : wdata;
  assign w_wbe   = w_clr_we ? '1 : wbe;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < int'(BE_WIDTH); i++) begin
        if (w_wbe[i]) r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // Read word with write-first forwarding of a same-address write.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_range) begin
      if (w_collide) begin
        w_rd_word = DATA_WIDTH'(merge_be(MERGE_MAX_W'(r_mem[rdaddr]),
                                         MERGE_MAX_W'(wdata),
                                         MERGE_MAX_BE'(wbe)));
      end else begin
        w_rd_word = r_mem[rdaddr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q      <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_ok;
      if (w_rd_ok) r_q <= w_rd_word;
    end
  end

`ifdef BRAM_BE_OUTREG_EN
  logic [DATA_WIDTH-1:0] r_q_o;
  logic                  r_rvalid_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_o      <= '0;
      r_rvalid_o <= 1'b0;
    end else begin
      r_q_o      <= r_q;
      r_rvalid_o <= r_rvalid;
    end
  end

  assign q      = r_q_o;
  assign rvalid = r_rvalid_o;
`else
  assign q      = r_q;
  assign rvalid = r_rvalid;
`endif

  assign busy = w_busy;

  // Debug snapshot of the array contents.
  task automatic dump_mem(output logic [DATA_WIDTH-1:0] o_arr [DEPTH]);
    for (int i = 0; i < int'(DEPTH); i++) o_arr[i] = r_mem[i];
  endtask

endmodule

// File: tb/tb_bram_be.sv
// Directed bench for bram_be with DEPTH=10 so out-of-range addresses exist.
module tb_bram_be;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 10;
  localparam int unsigned AW    = 4;
  localparam int unsigned BEW   = 4;
`ifdef BRAM_BE_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          busy;
  logic          rden;
  logic [AW-1:0] rdaddr;
  logic [DW-1:0] q;
  logic          rvalid;
  logic          wren;
  logic [AW-1:0] wraddr;
  logic [DW-1:0] wdata;
  logic [BEW-1:0] wbe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_be #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .MEM_FILE   (""),
    .INIT_CLEAR (1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .busy   (busy),
    .rden   (rden),
    .rdaddr (rdaddr),
    .q      (q),
    .rvalid (rvalid),
    .wren   (wren),
    .wraddr (wraddr),
    .wdata  (wdata),
    .wbe    (wbe)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
    rden = 1'b1; rdaddr = a;
    step();
    rden = 1'b0;
    repeat (LAT - 1) step();
    d = q; v = rvalid;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
    wren = 1'b1; wraddr = a; wdata = d; wbe = be;
    step();
    wren = 1'b0;
  endtask

  // Counts samples with busy high, starting from the current one.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    int n;
    logic [DW-1:0] d;
    logic v;
    rst = 1'b1;
    step(); step();
    checks++;
    if (q !== 32'h0 || rvalid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_vals: q=%h rvalid=%b busy=%b, want q=0 rvalid=0 busy=1", q, rvalid, busy);
    end
    rst = 1'b0;
    count_busy(n);
    checks++;
    if (n != int'(DEPTH)) begin
      errors++;
      $display("FAIL init_clear_len: busy for %0d cycles, want %0d", n, DEPTH);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      do_read(AW'(i), d, v);
      checks++;
      if (d !== 32'h0 || v !== 1'b1) begin
        errors++;
        $display("FAIL init_read[%0d]: q=%h rvalid=%b, want 00000000/1", i, d, v);
      end
    end
    step();
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_strobe: rvalid=%b, want 0", rvalid);
    end
  endtask

  task automatic test_byte_merge();
    logic [DW-1:0] d;
    logic v;
    do_write(4'd5, 32'hAABBCCDD, 4'b1111);
    do_write(4'd5, 32'h11223344, 4'b0101);
    do_write(4'd5, 32'h99999999, 4'b0000);
    do_read(4'd5, d, v);
    checks++;
    if (d !== 32'hAA22CC44 || v !== 1'b1) begin
      errors++;
      $display("FAIL byte_merge: q=%h rvalid=%b, want aa22cc44/1", d, v);
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] d;
    logic v;
    rden = 1'b1; rdaddr = 4'd7;
    wren = 1'b1; wraddr = 4'd7; wdata = 32'hDEADBEEF; wbe = 4'b0011;
    step();
    rden = 1'b0; wren = 1'b0;
    repeat (LAT - 1) step();
    checks++;
    if (q !== 32'h0000BEEF || rvalid !== 1'b1) begin
      errors++;
      $display("FAIL collide_fwd: q=%h rvalid=%b, want 0000beef/1", q, rvalid);
    end
    do_read(4'd7, d, v);
    checks++;
    if (d !== 32'h0000BEEF) begin
      errors++;
      $display("FAIL collide_after: q=%h, want 0000beef", d);
    end
    // Collision with no byte enables returns the stored word.
    rden = 1'b1; rdaddr = 4'd5;
    wren = 1'b1; wraddr = 4'd5; wdata = 32'h12345678; wbe = 4'b0000;
    step();
    rden = 1'b0; wren = 1'b0;
    repeat (LAT - 1) step();
    checks++;
    if (q !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL collide_be0: q=%h, want aa22cc44", q);
    end
  endtask

  task automatic test_oob();
    logic [DW-1:0] d;
    logic v;
    do_write(4'd12, 32'hCAFEF00D, 4'b1111);
    do_read(4'd12, d, v);
    checks++;
    if (d !== 32'h0 || v !== 1'b1) begin
      errors++;
      $display("FAIL oob_read: q=%h rvalid=%b, want 00000000/1", d, v);
    end
    do_read(4'd2, d, v);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL oob_alias: addr2 q=%h, want 00000000", d);
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    logic [DW-1:0] exp_d;
    logic exp_v;
    do_write(4'd1, 32'h00000101, 4'b1111);
    do_write(4'd2, 32'h00000202, 4'b1111);
    do_write(4'd3, 32'h00000303, 4'b1111);
    for (int k = 1; k <= 3 + LAT; k++) begin
      if (k <= 3) begin
        rden = 1'b1; rdaddr = AW'(k);
      end else begin
        rden = 1'b0;
      end
      step();
      idx   = k - LAT + 1;
      exp_v = (idx >= 1 && idx <= 3);
      exp_d = {16'h0, 8'(idx), 8'(idx)};
      checks++;
      if (rvalid !== exp_v || (exp_v && q !== exp_d)) begin
        errors++;
        $display("FAIL b2b[%0d]: q=%h rvalid=%b, want %h/%b", k, q, rvalid, exp_d, exp_v);
      end
    end
  endtask

  task automatic test_clear_busy();
    int n;
    logic [DW-1:0] q_hold;
    logic [DW-1:0] d;
    logic v;
    logic saw_rv;
    logic q_moved;
    q_hold = q;
    clr = 1'b1;
    step();
    clr = 1'b0;
    n = 0; saw_rv = 1'b0; q_moved = 1'b0;
    while (busy && n < 100) begin
      n++;
      if (rvalid !== 1'b0) saw_rv = 1'b1;
      if (q !== q_hold) q_moved = 1'b1;
      rden = (n == 1); rdaddr = 4'd3;
      wren = (n == 1); wraddr = 4'd4; wdata = 32'hFFFFFFFF; wbe = 4'b1111;
      clr  = (n == 3);
      step();
    end
    rden = 1'b0; wren = 1'b0; clr = 1'b0;
    checks++;
    if (n != int'(DEPTH)) begin
      errors++;
      $display("FAIL clr_len: busy for %0d cycles, want %0d", n, DEPTH);
    end
    checks++;
    if (saw_rv || q_moved || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL busy_read_drop: rvalid seen=%b q moved=%b, want 0/0", saw_rv, q_moved);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      do_read(AW'(i), d, v);
      checks++;
      if (d !== 32'h0 || v !== 1'b1) begin
        errors++;
        $display("FAIL post_clr[%0d]: q=%h rvalid=%b, want 00000000/1", i, d, v);
      end
    end
  endtask

  task automatic test_reset_midclear();
    int n;
    logic [DW-1:0] d;
    logic v;
    do_write(4'd6, 32'h00000066, 4'b1111);
    do_read(4'd6, d, v);
    checks++;
    if (d !== 32'h00000066) begin
      errors++;
      $display("FAIL pre_rst_read: q=%h, want 00000066", d);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || q !== 32'h0 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL midclr_rst: busy=%b q=%h rvalid=%b, want 1/00000000/0", busy, q, rvalid);
    end
    step();
    rst = 1'b0;
    count_busy(n);
    checks++;
    if (n != int'(DEPTH)) begin
      errors++;
      $display("FAIL midclr_len: busy for %0d cycles after rst, want %0d", n, DEPTH);
    end
    do_read(4'd6, d, v);
    checks++;
    if (d !== 32'h0 || v !== 1'b1) begin
      errors++;
      $display("FAIL midclr_read: q=%h rvalid=%b, want 00000000/1", d, v);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    rden = 1'b0; rdaddr = '0;
    wren = 1'b0; wraddr = '0; wdata = '0; wbe = '0;
    test_reset();
    test_byte_merge();
    test_collision();
    test_oob();
    test_back_to_back();
    test_clear_busy();
    test_reset_midclear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
